// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60Hz VGA timing constants shared by the raster pipeline
//
// Purpose: single home for the horizontal/vertical timing numbers so that
// vga_timing_gen and display_controller agree on H_DISPLAY/V_DISPLAY.
// Ports: none (package).
package vga_pkg;

  // Counter width for both raster axes; 799 and 524 both fit in 10 bits.
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // System clocks per pixel (100 MHz -> 25 MHz).
  localparam int CLK_DIV = 4;

  localparam int H_DISPLAY = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;

  localparam int V_DISPLAY = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  // Active level of both sync pins (0 = active-low).
  localparam bit SYNC_POL = 1'b0;

  localparam int H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_DISPLAY + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Half-open window test [lo, hi) on a raster coordinate.
  function automatic logic in_window(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// rtl/pixel_tick_div.sv - system-clock to pixel-rate divider producing pix_tick
//
// Purpose: counts 0..CLK_DIV-1 and marks the last count of each pixel period.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   pix_tick   out  high for the one clk in which the divider sits at CLK_DIV-1
//   tick_next  out  high in the clk before pix_tick; registers that must present
//                   new values during the pix_tick cycle load on this
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick,
  output logic tick_next
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // Looking at the next divider value lets pix_tick be a flop while still
  // coinciding exactly with div_q == CLK_DIV-1.
  assign tick_next = (div_d == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      pix_tick <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_tick <= tick_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (counters, decode, output registers)
//
// Purpose: walks the raster one pixel per pix_tick and presents registered,
// mutually consistent coordinates, blanking and sync for display_controller
// and the monitor, plus line/frame strobes and a completed-frame counter.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   pix_tick     out  one-clk pulse per pixel; pixel outputs change with it
//   h_cnt        out  presented pixel column, 0..H_TOTAL-1
//   v_cnt        out  presented line, 0..V_TOTAL-1
//   valid        out  presented pixel lies in the visible area
//   hsync        out  horizontal sync, SYNC_POL when active
//   vsync        out  vertical sync, SYNC_POL when active
//   line_start   out  high during the pix_tick that presents h_cnt=0
//   frame_start  out  high during the pix_tick that presents h_cnt=0,v_cnt=0
//   frame_cnt    out  frames completed since reset, wraps 255->0
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = vga_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP,
  parameter bit SYNC_POL  = vga_pkg::SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             valid,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam cnt_t HC_LAST  = cnt_t'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t VC_LAST  = cnt_t'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_DISPLAY);
  localparam cnt_t V_VIS    = cnt_t'(V_DISPLAY);
  localparam cnt_t HS_START = cnt_t'(H_DISPLAY + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_DISPLAY + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_DISPLAY + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_DISPLAY + V_FP + V_SYNC);

  logic tick_next;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_div (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick),
    .tick_next(tick_next)
  );

  // Internal raster position: the pixel the next pix_tick will present.
  cnt_t hc;
  cnt_t vc;

  // Set by the first frame_start after reset so that only later frame
  // starts count as a completed frame.
  logic frame_seen;

  logic dec_valid;
  logic dec_hsync;
  logic dec_vsync;
  logic dec_line;
  logic dec_frame;

  always_comb begin
    dec_valid = (hc < H_VIS) && (vc < V_VIS);
    dec_hsync = in_window(hc, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    dec_vsync = in_window(vc, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    dec_line  = (hc == '0);
    dec_frame = (hc == '0) && (vc == '0);
  end

  // Raster counters advance after their value has been captured for output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (tick_next) begin
      if (hc == HC_LAST) begin
        hc <= '0;
        if (vc == VC_LAST) begin
          vc <= '0;
        end else begin
          vc <= vc + 1'b1;
        end
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Output registers load together from one decode so they never disagree.
  // Strobes are cleared on the edge that ends the pix_tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      valid       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      frame_seen  <= 1'b0;
    end else if (tick_next) begin
      h_cnt       <= hc;
      v_cnt       <= vc;
      valid       <= dec_valid;
      hsync       <= dec_hsync;
      vsync       <= dec_vsync;
      line_start  <= dec_line;
      frame_start <= dec_frame;
      if (dec_frame) begin
        frame_seen <= 1'b1;
        if (frame_seen) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic       pix_tick_a, valid_a, hsync_a, vsync_a, line_start_a, frame_start_a;
  logic [9:0] h_cnt_a, v_cnt_a;
  logic [7:0] frame_cnt_a;
  logic       pix_tick_b, valid_b, hsync_b, vsync_b, line_start_b, frame_start_b;
  logic [9:0] h_cnt_b, v_cnt_b;
  logic [7:0] frame_cnt_b;

  // Full-size 640x480 timing.
  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .pix_tick(pix_tick_a), .h_cnt(h_cnt_a), .v_cnt(v_cnt_a),
    .valid(valid_a), .hsync(hsync_a), .vsync(vsync_a), .line_start(line_start_a),
    .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
  );

  // Miniature raster (10x6 pixels, 2 clks/pixel) so hundreds of frames fit.
  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(5), .H_FP(1), .H_SYNC(2), .H_BP(2),
    .V_DISPLAY(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .pix_tick(pix_tick_b), .h_cnt(h_cnt_b), .v_cnt(v_cnt_b),
    .valid(valid_b), .hsync(hsync_b), .vsync(vsync_b), .line_start(line_start_b),
    .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
  );

  typedef struct {
    int h; int v; int val; int hs; int vs; int ls; int fs; int fc;
  } exp_t;

  int n_total = 0;
  int n_pass  = 0;
  int ka = 0, kb = 0, gap_a = 0, gap_b = 0;
  bit ticked_a = 1'b0, ticked_b = 1'b0;
  int hs_low_a = 0, val_a = 0, fs_seen_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  // Expected outputs for the k-th pixel tick since reset, straight from the
  // raster geometry: position is k modulo the line/frame size.
  task automatic model(input int k, input int hd, input int hf, input int hw, input int hb,
                       input int vd, input int vf, input int vw, input int vb,
                       output exp_t e);
    int ht, vt;
    ht   = hd + hf + hw + hb;
    vt   = vd + vf + vw + vb;
    e.h  = k % ht;
    e.v  = (k / ht) % vt;
    e.val = (e.h < hd && e.v < vd) ? 1 : 0;
    e.hs = (e.h >= hd + hf && e.h < hd + hf + hw) ? 0 : 1;
    e.vs = (e.v >= vd + vf && e.v < vd + vf + vw) ? 0 : 1;
    e.ls = (e.h == 0) ? 1 : 0;
    e.fs = (e.h == 0 && e.v == 0) ? 1 : 0;
    e.fc = (k / (ht * vt)) % 256;
  endtask

  function automatic logic [31:0] pack_exp(input exp_t e);
    return {1'b0, e.h[9:0], e.v[9:0], e.val[0], e.hs[0], e.vs[0], e.fc[7:0]};
  endfunction

  task automatic samp_a();
    exp_t e;
    logic [31:0] obs;
    obs = {1'b0, h_cnt_a, v_cnt_a, valid_a, hsync_a, vsync_a, frame_cnt_a};
    gap_a++;
    if (pix_tick_a) begin
      check("a_tick_period", gap_a, 4);
      gap_a = 0;
      model(ka, 640, 16, 96, 48, 480, 10, 2, 33, e);
      check("a_tick_outs", obs, pack_exp(e));
      check("a_tick_strobes", {line_start_a, frame_start_a}, {e.ls[0], e.fs[0]});
      if (ka < 800) begin
        if (hsync_a == 1'b0) hs_low_a++;
        if (valid_a) val_a++;
      end
      ka++;
      ticked_a = 1'b1;
    end else if (!ticked_a) begin
      check("a_rst_outs", obs, {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd0});
      check("a_rst_strobes", {line_start_a, frame_start_a}, 0);
    end else begin
      model(ka - 1, 640, 16, 96, 48, 480, 10, 2, 33, e);
      check("a_hold_outs", obs, pack_exp(e));
      check("a_idle_strobes", {line_start_a, frame_start_a}, 0);
    end
  endtask

  task automatic samp_b();
    exp_t e;
    logic [31:0] obs;
    obs = {1'b0, h_cnt_b, v_cnt_b, valid_b, hsync_b, vsync_b, frame_cnt_b};
    gap_b++;
    if (pix_tick_b) begin
      check("b_tick_period", gap_b, 2);
      gap_b = 0;
      model(kb, 5, 1, 2, 2, 3, 1, 1, 1, e);
      check("b_tick_outs", obs, pack_exp(e));
      check("b_tick_strobes", {line_start_b, frame_start_b}, {e.ls[0], e.fs[0]});
      if (frame_start_b) fs_seen_b++;
      kb++;
      ticked_b = 1'b1;
    end else if (!ticked_b) begin
      check("b_rst_outs", obs, {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd0});
      check("b_rst_strobes", {line_start_b, frame_start_b}, 0);
    end else begin
      model(kb - 1, 5, 1, 2, 2, 3, 1, 1, 1, e);
      check("b_hold_outs", obs, pack_exp(e));
      check("b_idle_strobes", {line_start_b, frame_start_b}, 0);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
    samp_a();
    samp_b();
  endtask

  // Entered 1 time unit after an edge: assert reset mid-cycle, confirm the
  // outputs drop at once, hold n clks, release mid-cycle.
  task automatic reset_a(input int n);
    #1 rst_a = 1'b1;
    ticked_a = 1'b0;
    #1;
    check("a_rst_async", {1'b0, h_cnt_a, v_cnt_a, valid_a, hsync_a, vsync_a, frame_cnt_a},
          {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd0});
    check("a_rst_async_strobes", {pix_tick_a, line_start_a, frame_start_a}, 0);
    repeat (n) clk_step();
    #1 rst_a = 1'b0;
    ka = 0;
    gap_a = 1;
  endtask

  task automatic reset_b(input int n);
    #1 rst_b = 1'b1;
    ticked_b = 1'b0;
    #1;
    check("b_rst_async", {1'b0, h_cnt_b, v_cnt_b, valid_b, hsync_b, vsync_b, frame_cnt_b},
          {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd0});
    check("b_rst_async_strobes", {pix_tick_b, line_start_b, frame_start_b}, 0);
    repeat (n) clk_step();
    #1 rst_b = 1'b0;
    kb = 0;
    gap_b = 1;
  endtask

  initial begin
    int next_rst;
    int guard;

    // Power-on reset for 5 clks, then release both instances together.
    repeat (5) clk_step();
    #1 rst_a = 1'b0;
    rst_b = 1'b0;
    ka = 0; kb = 0; gap_a = 1; gap_b = 1;

    // First line of the full-size raster; the small one is reset at random points.
    next_rst = $urandom_range(20, 400);
    for (int c = 0; c < 3400; c++) begin
      clk_step();
      if (c == next_rst && c < 3000) begin
        reset_b($urandom_range(1, 3));
        next_rst = c + $urandom_range(20, 400);
      end
    end
    check("a_line0_hsync_ticks", hs_low_a, 96);
    check("a_line0_valid_ticks", val_a, 640);

    // Mid-line reset of the full-size raster at h_cnt=300.
    guard = 0;
    while (!(ticked_a && pix_tick_a && h_cnt_a == 10'd300 && v_cnt_a == 10'd1) && guard < 4000) begin
      clk_step();
      guard++;
    end
    check("a_reach_h300", (guard < 4000) ? 1 : 0, 1);
    reset_a(1);
    repeat (8) clk_step();
    check("a_restart_ticks", ka, 2);

    // Uninterrupted run of the small raster through the frame_cnt wrap.
    reset_b(2);
    fs_seen_b = 0;
    guard = 0;
    while (kb < 256 * 60 + 10 && guard < 40000) begin
      clk_step();
      guard++;
    end
    check("b_long_run_done", (guard < 40000) ? 1 : 0, 1);
    check("b_frames_seen", fs_seen_b, 257);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
